// File: rtl/decode_stage.sv
// Registered instruction-decode stage: opcode decode, field extraction, valid/ready
// handshake, one-cycle load-use bubble and flush. Optional counters under DECODE_STATS_EN.
module decode_stage #(
  parameter int INSTR_W  = 16,
  parameter int OP_W     = 4,
  parameter int REG_AW   = 2,
  parameter int DATA_W   = 16,
  parameter bit SEXT_IMM = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_opcode,
  output logic              out_reg_write,
  output logic              out_reg_dst,
  output logic              out_alu_src1,
  output logic              out_alu_src2,
  output logic              out_mem_write,
  output logic              out_mem_to_reg,
  output logic [2:0]        out_alu_op,
  output logic [REG_AW-1:0] out_rs_addr,
  output logic [REG_AW-1:0] out_rt_addr,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_illegal,
  output logic              stall
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]       stat_decoded,
  output logic [31:0]       stat_stalls,
  output logic [15:0]       stat_illegal
`endif
);

  localparam int IMM_W = INSTR_W - OP_W - 2*REG_AW;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src1;
    logic       alu_src2;
    logic [2:0] alu_op;
    logic       mem_write;
    logic       mem_to_reg;
  } ctrl_t;

  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [IMM_W-1:0]  imm_raw;
  logic [DATA_W-1:0] imm_ext;

  assign op      = in_instr[INSTR_W-1 -: OP_W];
  assign rs      = in_instr[INSTR_W-OP_W-1 -: REG_AW];
  assign rt      = in_instr[INSTR_W-OP_W-REG_AW-1 -: REG_AW];
  assign rd      = in_instr[INSTR_W-OP_W-2*REG_AW-1 -: REG_AW];
  assign imm_raw = in_instr[IMM_W-1:0];

  generate
    if (SEXT_IMM) begin : g_sext
      assign imm_ext = DATA_W'($signed(imm_raw));
    end else begin : g_zext
      assign imm_ext = DATA_W'(imm_raw);
    end
  endgenerate

  ctrl_t dec_ctrl;
  logic  dec_rtype, dec_illegal;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    dec_ctrl    = '0;
    dec_rtype   = 1'b0;
    dec_illegal = 1'b0;
    case (op)
      OP_W'(4'h0): dec_ctrl = 9'b0_1_0_1_000_0_1;
      OP_W'(4'h1): dec_ctrl = 9'b1_0_0_1_000_1_0;
      OP_W'(4'h2): begin dec_ctrl = 9'b1_1_0_0_000_0_0; dec_rtype = 1'b1; end
      OP_W'(4'h3): dec_ctrl = 9'b0_1_0_1_000_0_0;
      OP_W'(4'h4): begin dec_ctrl = 9'b1_1_1_0_001_0_0; dec_rtype = 1'b1; end
      OP_W'(4'h5): begin dec_ctrl = 9'b1_1_0_0_010_0_0; dec_rtype = 1'b1; end
      OP_W'(4'h6): dec_ctrl = 9'b0_1_0_1_010_0_0;
      OP_W'(4'h7): begin dec_ctrl = 9'b1_1_0_0_011_0_0; dec_rtype = 1'b1; end
      OP_W'(4'h8): dec_ctrl = 9'b0_1_0_1_011_0_0;
      OP_W'(4'h9): dec_ctrl = 9'b0_1_0_1_100_0_0;
      OP_W'(4'hA): dec_ctrl = 9'b0_1_0_1_101_0_0;
      OP_W'(4'hB): begin dec_ctrl = 9'b0_0_0_0_110_0_0; dec_rtype = 1'b1; end
      OP_W'(4'hC): begin dec_ctrl = 9'b0_0_0_0_111_0_0; dec_rtype = 1'b1; end
      OP_W'(4'hD): begin dec_ctrl = 9'b1_1_1_0_010_0_0; dec_rtype = 1'b1; end
      default:     dec_illegal = 1'b1;
    endcase
  end

  // Load-use tracking: destination of the last load to leave, checked against the next instruction.
  logic              pend;
  logic [REG_AW-1:0] pend_dst;
  logic              reads_rt, uses, accept, load_leaving;

  assign reads_rt     = dec_rtype || (op == OP_W'(4'h1));
  assign uses         = (rs == pend_dst) || (reads_rt && (rt == pend_dst));
  assign stall        = pend && in_valid && uses;
  assign in_ready     = !flush && !stall && (!out_valid || out_ready);
  assign accept       = in_valid && in_ready;
  assign load_leaving = out_valid && out_ready && (out_opcode == '0) && !out_illegal;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_opcode     <= '0;
      out_reg_write  <= 1'b0;
      out_reg_dst    <= 1'b0;
      out_alu_src1   <= 1'b0;
      out_alu_src2   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_alu_op     <= '0;
      out_rs_addr    <= '0;
      out_rt_addr    <= '0;
      out_rd_addr    <= '0;
      out_imm        <= '0;
      out_illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_opcode     <= op;
      out_reg_write  <= dec_ctrl.reg_write;
      out_reg_dst    <= dec_ctrl.reg_dst;
      out_alu_src1   <= dec_ctrl.alu_src1;
      out_alu_src2   <= dec_ctrl.alu_src2;
      out_mem_write  <= dec_ctrl.mem_write;
      out_mem_to_reg <= dec_ctrl.mem_to_reg;
      out_alu_op     <= dec_ctrl.alu_op;
      out_rs_addr    <= rs;
      out_rt_addr    <= rt;
      out_rd_addr    <= dec_rtype ? rd : '0;
      out_imm        <= (dec_rtype || dec_illegal) ? '0 : imm_ext;
      out_illegal    <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A load leaving arms the hazard even when the same cycle would otherwise clear it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_dst <= '0;
    end else if (flush) begin
      pend <= 1'b0;
    end else if (load_leaving) begin
      pend     <= 1'b1;
      pend_dst <= out_rt_addr;
    end else if (stall || accept || !in_valid) begin
      pend <= 1'b0;
    end
  end

`ifdef DECODE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_decoded <= '0;
      stat_stalls  <= '0;
      stat_illegal <= '0;
    end else begin
      if (accept)                stat_decoded <= stat_decoded + 32'd1;
      if (stall)                 stat_stalls  <= stat_stalls + 32'd1;
      if (accept && dec_illegal) stat_illegal <= stat_illegal + 16'd1;
    end
  end
`endif

endmodule
